// File: rtl/priority_grant_ctrl.sv
// priority_grant_ctrl: 64-way fixed-priority grant controller with pending tracking and sticky duplicate-request flag
// Ports: clk, rst (async active-high); req/mask [63:0] set/inhibit pending bits;
//   grant_ready accepts the offer; clr_err clears dup_err;
//   grant_valid/grant_idx the offer; pending, any_pending, dup_err status.
module priority_grant_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] req,
  input  logic [63:0] mask,
  input  logic        grant_ready,
  input  logic        clr_err,
  output logic        grant_valid,
  output logic [5:0]  grant_idx,
  output logic [63:0] pending,
  output logic        any_pending,
  output logic        dup_err
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [63:0] elig, acc_bit, pending_n;
  logic [5:0] low_idx;
  logic acc, dup;
  always_comb begin
    elig = pending & ~mask;
    low_idx = '0;
    for (int i = 63; i >= 0; i--) if (elig[i]) low_idx = 6'(i);
    acc = state == OFFER && grant_ready;
    acc_bit = acc ? 64'd1 << grant_idx : '0;
    // a request landing on the bit being accepted re-arms it rather than counting as a duplicate
    pending_n = (pending & ~acc_bit) | req;
    dup = |(req & pending & ~acc_bit);
    state_n = state == IDLE ? (|elig ? OFFER : IDLE) : (acc ? IDLE : OFFER);
    grant_valid = state == OFFER;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      any_pending <= 1'b0;
      dup_err <= 1'b0;
      grant_idx <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      any_pending <= |pending_n;
      dup_err <= dup | (dup_err & ~clr_err);
      if (state == IDLE && |elig) grant_idx <= low_idx;
    end
endmodule

// File: tb/tb_priority_grant_ctrl.sv
// tb_priority_grant_ctrl: directed scenarios plus randomized run against a behavioural grant model
module tb_priority_grant_ctrl;
  logic clk = 0, rst = 1, grant_ready = 0, clr_err = 0;
  logic [63:0] req = '0, mask = '0;
  logic grant_valid, any_pending, dup_err;
  logic [5:0] grant_idx;
  logic [63:0] pending;
  int total = 0, bad = 0;
  bit m_off, m_dup;
  int m_idx;
  logic [63:0] m_pend;
  int grants[$];

  priority_grant_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .grant_ready(grant_ready),
    .clr_err(clr_err), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .pending(pending), .any_pending(any_pending), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_dup = 0; m_idx = 0; m_pend = '0;
  endtask

  task automatic check_all();
    chk("grant_valid", grant_valid, m_off);
    chk("grant_idx", grant_idx, m_idx);
    chk("pending", pending, m_pend);
    chk("any_pending", any_pending, m_pend != 0);
    chk("dup_err", dup_err, m_dup);
  endtask

  // one clock: model applies the rules using inputs stable at the edge, then outputs compared
  task automatic cyc();
    bit acc, d;
    logic [63:0] np;
    int low;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      acc = m_off && grant_ready;
      np = m_pend | req;
      d = 0;
      for (int i = 0; i < 64; i++)
        if (req[i] && m_pend[i] && !(acc && i == m_idx)) d = 1;
      if (acc && !req[m_idx]) np[m_idx] = 1'b0;
      if (!m_off) begin
        low = -1;
        for (int i = 63; i >= 0; i--) if (m_pend[i] && !mask[i]) low = i;
        if (low >= 0) begin m_off = 1; m_idx = low; end
      end else if (acc) m_off = 0;
      m_dup = d || (m_dup && !clr_err);
      m_pend = np;
    end
    #1;
    check_all();
    if (grant_valid && grant_ready) grants.push_back(int'(grant_idx));
  endtask

  task automatic idle_inputs();
    req = '0; mask = '0; grant_ready = 0; clr_err = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    check_all();
    req = '1;
    cyc();
    cyc();
    req = '0;
    rst = 0;
  endtask

  initial begin
    model_reset();
    reset_dut();

    // single request at 37
    req[37] = 1; grant_ready = 1;
    cyc();
    chk("r37_pend", pending[37], 1'b1);
    chk("r37_novalid", grant_valid, 1'b0);
    req = '0;
    cyc();
    chk("r37_valid", grant_valid, 1'b1);
    chk("r37_idx", grant_idx, 6'd37);
    cyc();
    chk("r37_cleared", pending[37], 1'b0);
    repeat (2) cyc();

    // three simultaneous requests, in priority order at 2-cycle spacing
    grants.delete();
    req[5] = 1; req[9] = 1; req[63] = 1; grant_ready = 1;
    cyc();
    req = '0;
    repeat (7) cyc();
    chk("multi_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("multi_g0", grants[0], 5);
      chk("multi_g1", grants[1], 9);
      chk("multi_g2", grants[2], 63);
    end
    chk("multi_anyp", any_pending, 1'b0);

    // masking: 10 offered while 3 masked, offer held stable, then 3
    idle_inputs();
    req[3] = 1; req[10] = 1; mask[3] = 1;
    cyc();
    req = '0;
    cyc();
    chk("mask_idx10", grant_idx, 6'd10);
    mask = '0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("mask_hold", {grant_valid, grant_idx}, {1'b1, 6'd10});
    end
    grant_ready = 1;
    cyc();
    cyc();
    chk("mask_idx3", {grant_valid, grant_idx}, {1'b1, 6'd3});
    cyc();
    chk("mask_empty", any_pending, 1'b0);

    // duplicate detection, clear, and set-wins-on-acceptance
    idle_inputs();
    req[12] = 1;
    cyc();
    req = '0;
    cyc();
    req[12] = 1;
    cyc();
    chk("dup_set", dup_err, 1'b1);
    req = '0; clr_err = 1;
    cyc();
    chk("dup_clr", dup_err, 1'b0);
    clr_err = 0; req[12] = 1; grant_ready = 1;
    cyc();
    chk("dup_accept_pend", pending[12], 1'b1);
    chk("dup_accept_err", dup_err, 1'b0);
    idle_inputs();
    repeat (2) cyc();

    // asynchronous reset mid-offer
    reset_dut();
    req[20] = 1;
    cyc();
    req = '0;
    cyc();
    chk("rst_pre_offer", {grant_valid, grant_idx}, {1'b1, 6'd20});
    #2 rst = 1;
    #1;
    chk("rst_async_valid", grant_valid, 1'b0);
    chk("rst_async_pend", pending, 64'd0);
    model_reset();
    cyc();
    rst = 0;
    req[1] = 1;
    cyc();
    req = '0;
    cyc();
    chk("rst_after_idx1", {grant_valid, grant_idx}, {1'b1, 6'd1});

    // randomized traffic
    for (int k = 0; k < 10000; k++) begin
      req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      mask = {$urandom, $urandom} & {$urandom, $urandom};
      grant_ready = ($urandom_range(0, 2) != 0);
      clr_err = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
